// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between a read-only fetch port and a read/write data port.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed DM priority.
module mem_port_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

    // The wait counter starts at LAT so that the capture cycle lines up with
    // mem_rdata arriving LAT cycles after the mem_en cycle.
    localparam logic [2:0] LAT_CNT = 3'(LAT);

    state_t     state;
    logic [2:0] cnt;
    logic       owner;
    logic       grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;

    always_comb begin
        grant_dm = dm_req && (!if_req || (last_owner == OWNER_IF));
    end
`else
    // The data port belongs to the older instruction, so it always wins.
    always_comb begin
        grant_dm = dm_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            owner     <= OWNER_IF;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            dm_rdata  <= 32'd0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= OWNER_IF;
`endif
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        state  <= ISSUE;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (grant_dm) begin
                            owner     <= OWNER_DM;
                            mem_addr  <= dm_addr;
                            mem_we    <= dm_we;
                            mem_wdata <= dm_wdata;
                        end else begin
                            owner    <= OWNER_IF;
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        state    <= DONE;
                        dm_ready <= 1'b1;
                    end else begin
                        cnt   <= LAT_CNT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= DONE;
                        if (owner == OWNER_DM) begin
                            dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner <= owner;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LAT=1,2,3) share request inputs,
// each with its own reset and a fixed-latency memory model that only shows data in the valid cycle.
module tb_mem_port_arbiter;

    localparam logic        H  = 1'b1;
    localparam logic        L  = 1'b0;
    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] D1 = 32'h2002_0005;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] VA = 32'hA5A5_0080;
    localparam logic [31:0] VB = 32'h5A5A_0044;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk;
    logic [2:0]  rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] rd_value;

    logic [2:0]       d_if_ready;
    logic [2:0]       d_dm_ready;
    logic [2:0]       d_mem_en;
    logic [2:0]       d_mem_we;
    logic [2:0]       d_busy;
    logic [2:0][31:0] d_if_rdata;
    logic [2:0][31:0] d_dm_rdata;
    logic [2:0][31:0] d_mem_addr;
    logic [2:0][31:0] d_mem_wdata;
    logic [2:0][31:0] d_mem_rdata;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance g has LAT = g+1; its memory drives real data only LAT cycles after mem_en.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0] en_sh;
        mem_port_arbiter #(.LAT(g + 1)) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_rdata (d_if_rdata[g]),
            .if_ready (d_if_ready[g]),
            .dm_req   (dm_req),
            .dm_we    (dm_we),
            .dm_addr  (dm_addr),
            .dm_wdata (dm_wdata),
            .dm_rdata (d_dm_rdata[g]),
            .dm_ready (d_dm_ready[g]),
            .mem_en   (d_mem_en[g]),
            .mem_we   (d_mem_we[g]),
            .mem_addr (d_mem_addr[g]),
            .mem_wdata(d_mem_wdata[g]),
            .mem_rdata(d_mem_rdata[g]),
            .busy     (d_busy[g])
        );
        always_ff @(posedge clk) en_sh <= {en_sh[1:0], d_mem_en[g]};
        assign d_mem_rdata[g] = en_sh[g] ? rd_value : BAD;
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic [31:0] rd;
        logic        en;
        logic        we;
        logic [31:0] ma;
        logic [31:0] mw;
        logic        ifr;
        logic        dmr;
        logic        bsy;
        logic [31:0] ifd;
        logic [31:0] dmd;
    } vec_t;

    vec_t vec [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int g, input vec_t v);
        chk($sformatf("%s mem_en", tag),    32'(d_mem_en[g]),   32'(v.en));
        chk($sformatf("%s mem_we", tag),    32'(d_mem_we[g]),   32'(v.we));
        chk($sformatf("%s mem_addr", tag),  d_mem_addr[g],      v.ma);
        chk($sformatf("%s mem_wdata", tag), d_mem_wdata[g],     v.mw);
        chk($sformatf("%s if_ready", tag),  32'(d_if_ready[g]), 32'(v.ifr));
        chk($sformatf("%s dm_ready", tag),  32'(d_dm_ready[g]), 32'(v.dmr));
        chk($sformatf("%s busy", tag),      32'(d_busy[g]),     32'(v.bsy));
        chk($sformatf("%s if_rdata", tag),  d_if_rdata[g],      v.ifd);
        chk($sformatf("%s dm_rdata", tag),  d_dm_rdata[g],      v.dmd);
    endtask

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
    endtask

    initial begin
        vec_t zero_v;
        logic [2:0] order;
        int events;
        logic seen_ready;

        checks   = 0;
        failures = 0;
        rst      = 3'b111;
        rd_value = 32'h0;
        idle_inputs();

        // write 0x54, then IF read 0x40, then contended DM read 0x80 / IF read 0x44 (LAT=2)
        vec[0]  = '{L, Z,     H, H, 32'h54, DB, D1,  L, L, Z,      Z,  L, L, L, Z,  Z};
        vec[1]  = '{L, Z,     H, H, 32'h54, DB, D1,  H, H, 32'h54, DB, L, L, H, Z,  Z};
        vec[2]  = '{L, Z,     L, L, Z,      Z,  D1,  L, H, 32'h54, DB, L, H, H, Z,  Z};
        vec[3]  = '{H, 32'h40, L, L, Z,     Z,  D1,  L, H, 32'h54, DB, L, L, L, Z,  Z};
        vec[4]  = '{H, 32'h40, L, L, Z,     Z,  D1,  H, L, 32'h40, DB, L, L, H, Z,  Z};
        vec[5]  = '{H, 32'h40, L, L, Z,     Z,  D1,  L, L, 32'h40, DB, L, L, H, Z,  Z};
        vec[6]  = '{H, 32'h40, L, L, Z,     Z,  D1,  L, L, 32'h40, DB, L, L, H, Z,  Z};
        vec[7]  = '{L, Z,     L, L, Z,      Z,  D1,  L, L, 32'h40, DB, H, L, H, D1, Z};
        vec[8]  = '{H, 32'h44, H, L, 32'h80, Z, VA,  L, L, 32'h40, DB, L, L, L, D1, Z};
        vec[9]  = '{H, 32'h44, H, L, 32'h80, Z, VA,  H, L, 32'h80, Z,  L, L, H, D1, Z};
        vec[10] = '{H, 32'h44, H, L, 32'h80, Z, VA,  L, L, 32'h80, Z,  L, L, H, D1, Z};
        vec[11] = '{H, 32'h44, H, L, 32'h80, Z, VA,  L, L, 32'h80, Z,  L, L, H, D1, Z};
        vec[12] = '{H, 32'h44, L, L, Z,     Z,  VA,  L, L, 32'h80, Z,  L, H, H, D1, VA};
        vec[13] = '{H, 32'h44, L, L, Z,     Z,  VB,  L, L, 32'h80, Z,  L, L, L, D1, VA};
        vec[14] = '{H, 32'h44, L, L, Z,     Z,  VB,  H, L, 32'h44, Z,  L, L, H, D1, VA};
        vec[15] = '{H, 32'h44, L, L, Z,     Z,  VB,  L, L, 32'h44, Z,  L, L, H, D1, VA};
        vec[16] = '{H, 32'h44, L, L, Z,     Z,  VB,  L, L, 32'h44, Z,  L, L, H, D1, VA};
        vec[17] = '{L, Z,     L, L, Z,      Z,  VB,  L, L, 32'h44, Z,  H, L, H, VB, VA};
        vec[18] = '{L, Z,     L, L, Z,      Z,  VB,  L, L, 32'h44, Z,  L, L, L, VB, VA};

        repeat (3) @(posedge clk);
        #1;
        rst = 3'b000;

        zero_v = '{L, Z, L, L, Z, Z, Z, L, L, Z, Z, L, L, L, Z, Z};
        for (int g = 0; g < 3; g++) chk_all($sformatf("reset[%0d]", g), g, zero_v);

        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), 1, vec[i]);
            if_req   = vec[i].ir;
            if_addr  = vec[i].ia;
            dm_req   = vec[i].dr;
            dm_we    = vec[i].dw;
            dm_addr  = vec[i].da;
            dm_wdata = vec[i].dd;
            rd_value = vec[i].rd;
        end
        idle_inputs();
        repeat (8) @(posedge clk);

        // Reset in the middle of a LAT=3 fetch read discards the transaction.
        #1;
        if_req   = 1'b1;
        if_addr  = 32'h40;
        rd_value = 32'h7777_0001;
        @(posedge clk); #1;
        chk("t5 busy c1", 32'(d_busy[2]), 32'd1);
        chk("t5 mem_en c1", 32'(d_mem_en[2]), 32'd1);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        chk("t5 busy c3", 32'(d_busy[2]), 32'd0);
        chk("t5 mem_en c3", 32'(d_mem_en[2]), 32'd0);
        chk("t5 if_ready c3", 32'(d_if_ready[2]), 32'd0);
        chk("t5 if_rdata c3", d_if_rdata[2], 32'd0);
        chk("t5 mem_addr c3", d_mem_addr[2], 32'd0);
        rst[2] = 1'b0;
        if_req = 1'b0;
        seen_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (d_if_ready[2] || d_dm_ready[2]) seen_ready = 1'b1;
        end
        chk("t5 no late ready", 32'(seen_ready), 32'd0);

        // LAT=1 data read.
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h10;
        rd_value = 32'h1234_5678;
        @(posedge clk); #1;
        chk("t6 mem_en c1", 32'(d_mem_en[0]), 32'd1);
        chk("t6 mem_we c1", 32'(d_mem_we[0]), 32'd0);
        chk("t6 mem_addr c1", d_mem_addr[0], 32'h10);
        @(posedge clk); #1;
        chk("t6 dm_ready c2", 32'(d_dm_ready[0]), 32'd0);
        @(posedge clk); #1;
        chk("t6 dm_ready c3", 32'(d_dm_ready[0]), 32'd1);
        chk("t6 dm_rdata c3", d_dm_rdata[0], 32'h1234_5678);
        dm_req = 1'b0;
        @(posedge clk); #1;
        chk("t6 dm_ready c4", 32'(d_dm_ready[0]), 32'd0);
        chk("t6 busy c4", 32'(d_busy[0]), 32'd0);
        idle_inputs();
        repeat (8) @(posedge clk);

        // Both ports held across three grants on the LAT=2 instance.
        #1;
        rst = 3'b111;
        @(posedge clk); #1;
        rst      = 3'b000;
        if_req   = 1'b1;
        if_addr  = 32'h44;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 32'h80;
        rd_value = 32'h0BAD_CAFE;
        order    = 3'b000;
        events   = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (d_if_ready[1] && d_dm_ready[1]) chk("t4 both ready", 32'd1, 32'd0);
            if (d_if_ready[1] || d_dm_ready[1]) begin
                order  = {order[1:0], d_dm_ready[1]};
                events = events + 1;
                if (events == 3) idle_inputs();
            end
        end
        chk("t4 ready count", 32'(events), 32'd3);
`ifdef ARB_ROUND_ROBIN_EN
        chk("t4 grant order", 32'(order), 32'(3'b101));
`else
        chk("t4 grant order", 32'(order), 32'(3'b111));
`endif
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
